// File: rtl/axis_i2s_pkg.sv
// Shared definitions for the I2S transmit scheduler: default word width,
// scheduler FSM states, source-select encoding and a saturating increment.
`timescale 1ns/1ps
package axis_i2s_pkg;

  localparam int DATA_W_DEFAULT = 64;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_PRESENT   = 2'd3
  } sched_state_e;

  typedef enum logic {
    SRC_DMA  = 1'b0,
    SRC_TONE = 1'b1
  } src_sel_e;

  // Event counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/axis_i2s_tx_sched_if.sv
// AXI-Stream style bundle used for both sample sources and the I2S-side sink.
`timescale 1ns/1ps
interface axis_i2s_tx_sched_if #(
  parameter int DATA_W = axis_i2s_pkg::DATA_W_DEFAULT
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_i2s_frame_tick.sv
// Free-running frame counter; strobes frame_tick on the last cycle of a frame.
`timescale 1ns/1ps
module axis_i2s_frame_tick #(
  parameter int FRAME_BITS = 8
) (
  input  logic aclk,
  input  logic resetn,
  input  logic enable,
  output logic frame_tick
);

  localparam logic [FRAME_BITS-1:0] CNT_MAX = {FRAME_BITS{1'b1}};
  localparam logic [FRAME_BITS-1:0] CNT_ONE = {{(FRAME_BITS-1){1'b0}}, 1'b1};

  logic [FRAME_BITS-1:0] cnt_r;
  logic [FRAME_BITS-1:0] cnt_nxt_s;
  logic                  tick_r;

  // Next counter value: count while enabled, park at zero otherwise.
  always_comb begin
    cnt_nxt_s = {FRAME_BITS{1'b0}};
    if (enable) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = {FRAME_BITS{1'b0}};
    end
  end

  // Counter register; the tick is registered so it lines up with cnt_r == max.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      cnt_r  <= {FRAME_BITS{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == CNT_MAX);
    end
  end

  assign frame_tick = tick_r;

endmodule

// File: rtl/axis_i2s_tx_sched.sv
// Frame-paced scheduler: once per frame fetches one word from the granted
// source and presents it to the I2S transmitter, tracking under/overruns.
`timescale 1ns/1ps
module axis_i2s_tx_sched
  import axis_i2s_pkg::*;
#(
  parameter int FRAME_BITS = 8,
  parameter int DATA_W     = DATA_W_DEFAULT
) (
  input  logic                        aclk,
  input  logic                        resetn,
  axis_i2s_tx_sched_if.slave          s0_axis,
  axis_i2s_tx_sched_if.slave          s1_axis,
  axis_i2s_tx_sched_if.master         m_axis,
  input  logic                        cfg_enable,
  input  logic                        cfg_src_sel,
  input  logic                        cfg_mute,
  output logic                        active_src,
  output logic                        frame_tick,
  output logic [15:0]                 underrun_cnt,
  output logic [15:0]                 overrun_cnt
);

  sched_state_e      state_r;
  sched_state_e      state_nxt_s;
  logic              fetch_nxt_s;
  logic              grant_nxt_s;
  logic              sel_valid_s;
  logic              sel_tlast_s;
  logic [DATA_W-1:0] sel_tdata_s;

  logic              active_src_r;
  logic              last_tlast_r;   // 1 = packet boundary reached, switching allowed
  logic              s0_tready_r;
  logic              s1_tready_r;
  logic              m_tvalid_r;
  logic              m_tlast_r;
  logic [DATA_W-1:0] m_tdata_r;
  logic [15:0]       underrun_r;
  logic [15:0]       overrun_r;

  axis_i2s_frame_tick #(
    .FRAME_BITS (FRAME_BITS)
  ) u_frame_tick (
    .aclk       (aclk),
    .resetn     (resetn),
    .enable     (cfg_enable),
    .frame_tick (frame_tick)
  );

  // Scheduler next state; dropping cfg_enable always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (!cfg_enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:      state_nxt_s = ST_WAIT_TICK;
        ST_WAIT_TICK: state_nxt_s = frame_tick ? ST_FETCH : ST_WAIT_TICK;
        ST_FETCH:     state_nxt_s = ST_PRESENT;
        ST_PRESENT: begin
          if (frame_tick) begin
            state_nxt_s = ST_FETCH;
          end else if (m_axis.tready) begin
            state_nxt_s = ST_WAIT_TICK;
          end else begin
            state_nxt_s = ST_PRESENT;
          end
        end
        default:      state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Grant for the upcoming fetch and the data path of the current grant.
  always_comb begin
    fetch_nxt_s = (state_nxt_s == ST_FETCH);
    grant_nxt_s = active_src_r;
    if (last_tlast_r) begin
      grant_nxt_s = cfg_src_sel;
    end else begin
      grant_nxt_s = active_src_r;
    end
    if (active_src_r == SRC_TONE) begin
      sel_valid_s = s1_axis.tvalid;
      sel_tlast_s = s1_axis.tlast;
      sel_tdata_s = s1_axis.tdata;
    end else begin
      sel_valid_s = s0_axis.tvalid;
      sel_tlast_s = s0_axis.tlast;
      sel_tdata_s = s0_axis.tdata;
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Source grant and one-cycle tready pulse, decided on the edge entering FETCH.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      active_src_r <= SRC_DMA;
      s0_tready_r  <= 1'b0;
      s1_tready_r  <= 1'b0;
    end else begin
      s0_tready_r <= fetch_nxt_s && (grant_nxt_s == SRC_DMA);
      s1_tready_r <= fetch_nxt_s && (grant_nxt_s == SRC_TONE);
      if (fetch_nxt_s) begin
        active_src_r <= grant_nxt_s;
      end else begin
        active_src_r <= active_src_r;
      end
    end
  end

  // Word capture, presentation to the sink and under/overrun accounting.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_tdata_r    <= {DATA_W{1'b0}};
      m_tvalid_r   <= 1'b0;
      m_tlast_r    <= 1'b0;
      last_tlast_r <= 1'b1;
      underrun_r   <= 16'd0;
      overrun_r    <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Leaving IDLE always allows a fresh source choice.
          last_tlast_r <= 1'b1;
          m_tvalid_r   <= 1'b0;
        end
        ST_FETCH: begin
          if (sel_valid_s) begin
            m_tdata_r    <= cfg_mute ? {DATA_W{1'b0}} : sel_tdata_s;
            m_tlast_r    <= sel_tlast_s;
            last_tlast_r <= sel_tlast_s;
          end else begin
            // Underrun: emit silence and treat it as a packet boundary.
            m_tdata_r    <= {DATA_W{1'b0}};
            m_tlast_r    <= 1'b0;
            last_tlast_r <= 1'b1;
            underrun_r   <= sat_inc(underrun_r);
          end
          m_tvalid_r <= (state_nxt_s == ST_PRESENT);
        end
        ST_PRESENT: begin
          if (!cfg_enable) begin
            m_tvalid_r <= 1'b0;
          end else if (m_axis.tready) begin
            m_tvalid_r <= 1'b0;
          end else if (frame_tick) begin
            // Sink missed the whole frame: drop the held word.
            m_tvalid_r <= 1'b0;
            overrun_r  <= sat_inc(overrun_r);
          end else begin
            m_tvalid_r <= 1'b1;
          end
        end
        default: begin
          m_tvalid_r <= 1'b0;
        end
      endcase
    end
  end

  assign s0_axis.tready = s0_tready_r;
  assign s1_axis.tready = s1_tready_r;
  assign m_axis.tdata   = m_tdata_r;
  assign m_axis.tvalid  = m_tvalid_r;
  assign m_axis.tlast   = m_tlast_r;
  assign active_src     = active_src_r;
  assign underrun_cnt   = underrun_r;
  assign overrun_cnt    = overrun_r;

endmodule

// File: tb/tb_axis_i2s_tx_sched.sv
// Directed bench for axis_i2s_tx_sched with FRAME_BITS=4 (16-cycle frames).
`timescale 1ns/1ps
module tb_axis_i2s_tx_sched;
  import axis_i2s_pkg::*;

  localparam int FB = 4;
  localparam int DW = 64;

  localparam logic [DW-1:0] W_S0   = 64'h1111_1111_1111_1111;
  localparam logic [DW-1:0] W_S1   = 64'h5555_5555_5555_5555;
  localparam logic [DW-1:0] W_A    = 64'h3333_3333_3333_3333;
  localparam logic [DW-1:0] W_B    = 64'h4444_4444_4444_4444;
  localparam logic [DW-1:0] W_AAAA = 64'hAAAA_AAAA_AAAA_AAAA;

  logic        aclk = 1'b0;
  logic        resetn;
  logic        cfg_enable;
  logic        cfg_src_sel;
  logic        cfg_mute;
  logic        active_src;
  logic        frame_tick;
  logic [15:0] underrun_cnt;
  logic [15:0] overrun_cnt;

  axis_i2s_tx_sched_if #(.DATA_W(DW)) s0_if ();
  axis_i2s_tx_sched_if #(.DATA_W(DW)) s1_if ();
  axis_i2s_tx_sched_if #(.DATA_W(DW)) m_if ();

  axis_i2s_tx_sched #(
    .FRAME_BITS (FB),
    .DATA_W     (DW)
  ) dut (
    .aclk         (aclk),
    .resetn       (resetn),
    .s0_axis      (s0_if),
    .s1_axis      (s1_if),
    .m_axis       (m_if),
    .cfg_enable   (cfg_enable),
    .cfg_src_sel  (cfg_src_sel),
    .cfg_mute     (cfg_mute),
    .active_src   (active_src),
    .frame_tick   (frame_tick),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] words[$];
  int s0_pulses = 0;
  int s1_pulses = 0;

  // Record every completed sink transfer and every source tready pulse.
  always @(posedge aclk) begin
    if (m_if.tvalid && m_if.tready) words.push_back(m_if.tdata);
    if (s0_if.tready) s0_pulses <= s0_pulses + 1;
    if (s1_if.tready) s1_pulses <= s1_pulses + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge where frame_tick is high; report cycles taken.
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge aclk);
      cyc++;
    end while (!frame_tick && cyc < 200);
    if (!frame_tick) check("tick_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int cyc;
    int base;
    int p0;
    logic [DW-1:0] exp_sw[5];

    resetn          = 1'b0;
    cfg_enable      = 1'b0;
    cfg_src_sel     = 1'b0;
    cfg_mute        = 1'b0;
    s0_if.tdata     = W_S0;
    s0_if.tvalid    = 1'b1;
    s0_if.tlast     = 1'b1;
    s1_if.tdata     = W_S1;
    s1_if.tvalid    = 1'b1;
    s1_if.tlast     = 1'b1;
    m_if.tready     = 1'b1;
    repeat (3) @(negedge aclk);

    // Reset state
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_if.tdata), 64'd0);
    check("rst_s0_tready", 64'(s0_if.tready), 64'd0);
    check("rst_s1_tready", 64'(s1_if.tready), 64'd0);
    check("rst_frame_tick", 64'(frame_tick), 64'd0);
    check("rst_active_src", 64'(active_src), 64'd0);
    check("rst_underrun", 64'(underrun_cnt), 64'd0);
    check("rst_overrun", 64'(overrun_cnt), 64'd0);

    // Basic streaming from s0 with the sink always ready
    resetn     = 1'b1;
    cfg_enable = 1'b1;
    wait_tick(cyc);
    check("first_tick_cycles", 64'(cyc), 64'd15);
    @(negedge aclk);
    check("fetch_s0_tready", 64'(s0_if.tready), 64'd1);
    check("fetch_s1_tready", 64'(s1_if.tready), 64'd0);
    @(negedge aclk);
    check("present_tvalid", 64'(m_if.tvalid), 64'd1);
    check("present_tdata", 64'(m_if.tdata), 64'(W_S0));
    check("present_s0_tready_low", 64'(s0_if.tready), 64'd0);
    wait_tick(cyc);
    check("tick_period", 64'(cyc), 64'd14);
    base = words.size();
    p0   = s0_pulses;
    repeat (64) @(negedge aclk);
    check("xfers_per_4_frames", 64'(words.size() - base), 64'd4);
    check("s0_pulses_per_4_frames", 64'(s0_pulses - p0), 64'd4);
    check("no_underrun_yet", 64'(underrun_cnt), 64'd0);
    check("no_overrun_yet", 64'(overrun_cnt), 64'd0);

    // Three frames of source underrun
    wait_tick(cyc);
    s0_if.tvalid = 1'b0;
    base = words.size();
    repeat (3) wait_tick(cyc);
    s0_if.tvalid = 1'b1;
    check("underrun_cnt_3", 64'(underrun_cnt), 64'd3);
    repeat (3) @(negedge aclk);
    check("underrun_word_count", 64'(words.size() - base), 64'd4);
    for (int i = 0; i < 3; i++) check($sformatf("underrun_zero_%0d", i), 64'(words[base+i]), 64'd0);
    check("after_underrun_word", 64'(words[base+3]), 64'(W_S0));

    // Sink stalls 40 cycles: two frames dropped, then a fresh word
    wait_tick(cyc);
    m_if.tready = 1'b0;
    s0_if.tdata = W_A;
    base = words.size();
    repeat (20) @(negedge aclk);
    s0_if.tdata = W_B;
    repeat (20) @(negedge aclk);
    m_if.tready = 1'b1;
    @(negedge aclk);
    check("overrun_cnt_2", 64'(overrun_cnt), 64'd2);
    check("overrun_xfer_count", 64'(words.size() - base), 64'd1);
    check("overrun_fresh_word", 64'(words[base]), 64'(W_B));

    // Source switch requested mid-packet; takes effect after tlast
    exp_sw = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
               64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404, W_S1};
    wait_tick(cyc);
    s0_if.tdata = exp_sw[0];
    s0_if.tlast = 1'b0;
    base = words.size();
    @(negedge aclk);
    check("sw_src_word1", 64'(active_src), 64'd0);
    @(negedge aclk);
    cfg_src_sel = 1'b1;
    wait_tick(cyc);
    s0_if.tdata = exp_sw[1];
    wait_tick(cyc);
    s0_if.tdata = exp_sw[2];
    wait_tick(cyc);
    s0_if.tdata = exp_sw[3];
    s0_if.tlast = 1'b1;
    @(negedge aclk);
    check("sw_src_word4", 64'(active_src), 64'd0);
    check("sw_s0_tready_word4", 64'(s0_if.tready), 64'd1);
    wait_tick(cyc);
    @(negedge aclk);
    check("sw_src_word5", 64'(active_src), 64'd1);
    check("sw_s1_tready_word5", 64'(s1_if.tready), 64'd1);
    check("sw_s0_tready_word5", 64'(s0_if.tready), 64'd0);
    repeat (2) @(negedge aclk);
    check("sw_word_count", 64'(words.size() - base), 64'd5);
    for (int i = 0; i < 5; i++) check($sformatf("sw_word_%0d", i), 64'(words[base+i]), 64'(exp_sw[i]));

    // Mute: zeros out, consumption unchanged
    cfg_src_sel = 1'b0;
    cfg_mute    = 1'b1;
    s0_if.tdata = W_AAAA;
    wait_tick(cyc);
    base = words.size();
    p0   = s0_pulses;
    repeat (48) @(negedge aclk);
    check("mute_s0_pulses", 64'(s0_pulses - p0), 64'd3);
    check("mute_xfer_count", 64'(words.size() - base), 64'd3);
    for (int i = 0; i < 3; i++) check($sformatf("mute_zero_%0d", i), 64'(words[base+i]), 64'd0);
    check("mute_src_back_s0", 64'(active_src), 64'd0);

    // Reset pulse while a word is being presented
    cfg_mute    = 1'b0;
    m_if.tready = 1'b0;
    wait_tick(cyc);
    repeat (2) @(negedge aclk);
    check("pre_rst_tvalid", 64'(m_if.tvalid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_async_underrun", 64'(underrun_cnt), 64'd0);
    check("rst_async_overrun", 64'(overrun_cnt), 64'd0);
    check("rst_async_active_src", 64'(active_src), 64'd0);
    @(negedge aclk);
    resetn      = 1'b1;
    m_if.tready = 1'b1;
    base = words.size();
    wait_tick(cyc);
    check("restart_tick_cycles", 64'(cyc), 64'd15);
    check("no_partial_word", 64'(words.size() - base), 64'd0);
    repeat (3) @(negedge aclk);
    check("restart_xfer_count", 64'(words.size() - base), 64'd1);
    check("restart_word", 64'(words[base]), 64'(W_AAAA));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
